// File: rtl/cpu_pkg.sv
// Shared types and default widths for the multi-cycle core sequencer.
// Instruction layout: op[11:9] src1[8:6] src2[5:3] dst[2:0].
package cpu_pkg;

    localparam int DEF_PC_W    = 3;
    localparam int DEF_DATA_W  = 5;
    localparam int DEF_REG_AW  = 3;
    localparam int DEF_INSTR_W = 12;
    localparam int DEF_CNT_W   = 8;
    localparam int OP_W        = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_JMP = 3'd1,
        OP_AND = 3'd2,
        OP_XOR = 3'd3
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_PAUSE  = 3'd6
    } seq_state_e;

endpackage

// File: rtl/cpu_sequencer_decode.sv
// Combinational instruction splitter: IR -> opcode, register fields and class flags.
// Opcodes 4..7 are flagged illegal.
module seq_decode
    import cpu_pkg::*;
#(
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int REG_AW  = DEF_REG_AW
) (
    input  logic [INSTR_W-1:0] ir,
    output logic [OP_W-1:0]    op,
    output logic [REG_AW-1:0]  src1,
    output logic [REG_AW-1:0]  src2,
    output logic [REG_AW-1:0]  dst,
    output logic               is_alu,
    output logic               is_jmp,
    output logic               is_illegal
);

    assign op   = ir[INSTR_W-1 -: OP_W];
    assign src1 = ir[3*REG_AW-1 -: REG_AW];
    assign src2 = ir[2*REG_AW-1 -: REG_AW];
    assign dst  = ir[REG_AW-1:0];

    always_comb begin
        is_alu = 1'b0;
        is_jmp = 1'b0;
        case (op)
            OP_ADD, OP_AND, OP_XOR: is_alu = 1'b1;
            OP_JMP:                 is_jmp = 1'b1;
            default: ;
        endcase
    end

    assign is_illegal = !(is_alu || is_jmp);

endmodule

// File: rtl/cpu_sequencer.sv
// FETCH/DECODE/EXEC/WB controller: PC, IR, operand latches, trap and retired counter.
// SEQ_STEP_EN adds a `step` input and a PAUSE state after every write-back.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_AW  = DEF_REG_AW,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               halt_req,
    output logic [PC_W-1:0]    rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [REG_AW-1:0]  rf_rd_addr1,
    output logic [REG_AW-1:0]  rf_rd_addr2,
    input  logic [DATA_W-1:0]  rf_rd_data1,
    input  logic [DATA_W-1:0]  rf_rd_data2,
    output logic [OP_W-1:0]    alu_op,
    input  logic [DATA_W-1:0]  alu_result,
    output logic               rf_wr_en,
    output logic [REG_AW-1:0]  rf_wr_addr,
    output logic [DATA_W-1:0]  rf_wr_data,
    output logic               busy,
    output logic               halted,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
`ifdef SEQ_STEP_EN
    ,
    input  logic               step
`endif
);

    seq_state_e         state;
    seq_state_e         nxt;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [DATA_W-1:0]  r;
    logic               wr_en_q;

    logic [OP_W-1:0]    dec_op;
    logic [REG_AW-1:0]  dec_src1;
    logic [REG_AW-1:0]  dec_src2;
    logic [REG_AW-1:0]  dec_dst;
    logic               dec_alu;
    logic               dec_jmp;
    logic               dec_illegal;

    seq_decode #(
        .INSTR_W (INSTR_W),
        .REG_AW  (REG_AW)
    ) u_decode (
        .ir         (ir),
        .op         (dec_op),
        .src1       (dec_src1),
        .src2       (dec_src2),
        .dst        (dec_dst),
        .is_alu     (dec_alu),
        .is_jmp     (dec_jmp),
        .is_illegal (dec_illegal)
    );

    assign rom_addr   = pc;
    assign rf_wr_addr = dec_dst;
    assign rf_wr_data = r;
    // A write already staged for WB must not reach the register file in a reset cycle.
    assign rf_wr_en   = wr_en_q && !rst;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   if (run) nxt = halt_req ? S_HALT : S_FETCH;
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: nxt = dec_illegal ? S_HALT : S_EXEC;
            S_EXEC:   nxt = S_WB;
            S_WB: begin
                if (halt_req)  nxt = S_HALT;
                else if (!run) nxt = S_IDLE;
`ifdef SEQ_STEP_EN
                else           nxt = S_PAUSE;
`else
                else           nxt = S_FETCH;
`endif
            end
            // An illegal-opcode halt is left only through reset.
            S_HALT:   if (!illegal && !halt_req && run) nxt = S_FETCH;
`ifdef SEQ_STEP_EN
            S_PAUSE: begin
                if (halt_req)  nxt = S_HALT;
                else if (step) nxt = S_FETCH;
            end
`endif
            default:  nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            ir          <= '0;
            a           <= '0;
            b           <= '0;
            r           <= '0;
            wr_en_q     <= 1'b0;
            rf_rd_addr1 <= '0;
            rf_rd_addr2 <= '0;
            alu_op      <= '0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            retired     <= '0;
        end else begin
            state   <= nxt;
            busy    <= (nxt inside {S_FETCH, S_DECODE, S_EXEC, S_WB});
            halted  <= (nxt == S_HALT);
            wr_en_q <= 1'b0;
            case (state)
                S_FETCH: ir <= rom_data;
                S_DECODE: begin
                    rf_rd_addr1 <= dec_src1;
                    rf_rd_addr2 <= dec_src2;
                    alu_op      <= dec_op;
                    if (dec_illegal) illegal <= 1'b1;
                end
                S_EXEC: begin
                    a       <= rf_rd_data1;
                    b       <= rf_rd_data2;
                    r       <= alu_result;
                    wr_en_q <= dec_alu;
                end
                S_WB: begin
                    if (dec_jmp && (a == '0)) pc <= PC_W'(b);
                    else                      pc <= pc + PC_W'(1);
                    if (retired != '1) retired <= retired + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench: vector table for single instructions plus hand sequences for
// trap, halt, run-drop, reset abort, PC wrap and counter saturation.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        halt_req = 1'b0;
    logic [2:0]  rom_addr;
    logic [11:0] rom_data;
    logic [2:0]  rf_rd_addr1, rf_rd_addr2;
    logic [4:0]  rf_rd_data1, rf_rd_data2;
    logic [2:0]  alu_op;
    logic [4:0]  alu_result;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_addr;
    logic [4:0]  rf_wr_data;
    logic        busy, halted, illegal;
    logic [7:0]  retired;
`ifdef SEQ_STEP_EN
    logic        step = 1'b0;
`endif

    logic [11:0] rom [8];
    logic [4:0]  rf  [8];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rom_data    = rom[rom_addr];
    assign rf_rd_data1 = rf[rf_rd_addr1];
    assign rf_rd_data2 = rf[rf_rd_addr2];
    assign alu_result  = (alu_op == 3'd0) ? rf_rd_data1 + rf_rd_data2 :
                         (alu_op == 3'd2) ? rf_rd_data1 & rf_rd_data2 :
                         (alu_op == 3'd3) ? rf_rd_data1 ^ rf_rd_data2 : 5'd0;

    cpu_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .halt_req    (halt_req),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .rf_rd_addr1 (rf_rd_addr1),
        .rf_rd_addr2 (rf_rd_addr2),
        .rf_rd_data1 (rf_rd_data1),
        .rf_rd_data2 (rf_rd_data2),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_addr  (rf_wr_addr),
        .rf_wr_data  (rf_wr_data),
        .busy        (busy),
        .halted      (halted),
        .illegal     (illegal),
        .retired     (retired)
`ifdef SEQ_STEP_EN
        ,
        .step        (step)
`endif
    );

    typedef struct packed {
        logic [11:0] instr;
        logic [2:0]  ra;
        logic [4:0]  va;
        logic [2:0]  rb;
        logic [4:0]  vb;
        logic        wr_en;
        logic [2:0]  wr_addr;
        logic [4:0]  wr_data;
        logic [2:0]  pc;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge, register writes applied then.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rf_wr_en) rf[rf_wr_addr] = rf_wr_data;
    endtask

    task automatic clear_mem();
        for (int k = 0; k < 8; k++) begin
            rom[k] = 12'h000;
            rf[k]  = 5'd0;
        end
    endtask

    task automatic reset_dut();
        run = 1'b0;
        halt_req = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{12'h042, 3'd1, 5'd1,    3'd0, 5'd1,    1'b1, 3'd2, 5'h02, 3'd1};
        vecs[1] = '{12'h2E8, 3'd3, 5'd0,    3'd5, 5'd6,    1'b0, 3'd0, 5'h00, 3'd6};
        vecs[2] = '{12'h2E8, 3'd3, 5'd1,    3'd5, 5'd6,    1'b0, 3'd0, 5'h00, 3'd1};
        vecs[3] = '{12'h453, 3'd1, 5'h1B,   3'd2, 5'h0E,   1'b1, 3'd3, 5'h0A, 3'd1};
        vecs[4] = '{12'h737, 3'd4, 5'h15,   3'd6, 5'h0F,   1'b1, 3'd7, 5'h1A, 3'd1};
        vecs[5] = '{12'h1BD, 3'd6, 5'h1F,   3'd7, 5'h02,   1'b1, 3'd5, 5'h01, 3'd1};
        vecs[6] = '{12'h220, 3'd0, 5'h00,   3'd4, 5'h1D,   1'b0, 3'd0, 5'h00, 3'd5};

        clear_mem();
        reset_dut();
        check("reset_busy",    32'(busy),     32'd0);
        check("reset_halted",  32'(halted),   32'd0);
        check("reset_illegal", 32'(illegal),  32'd0);
        check("reset_retired", 32'(retired),  32'd0);
        check("reset_pc",      32'(rom_addr), 32'd0);
        check("reset_wr_en",   32'(rf_wr_en), 32'd0);
        check("reset_alu_op",  32'(alu_op),   32'd0);

        for (int i = 0; i < 7; i++) begin
            clear_mem();
            rom[0] = vecs[i].instr;
            rf[vecs[i].ra] = vecs[i].va;
            rf[vecs[i].rb] = vecs[i].vb;
            reset_dut();
            run = 1'b1;
            repeat (3) tick();
            check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
            tick();
            check($sformatf("v%0d_wr_en", i), 32'(rf_wr_en), 32'(vecs[i].wr_en));
            if (vecs[i].wr_en) begin
                check($sformatf("v%0d_wr_addr", i), 32'(rf_wr_addr), 32'(vecs[i].wr_addr));
                check($sformatf("v%0d_wr_data", i), 32'(rf_wr_data), 32'(vecs[i].wr_data));
            end
            tick();
            check($sformatf("v%0d_pc", i), 32'(rom_addr), 32'(vecs[i].pc));
            check($sformatf("v%0d_retired", i), 32'(retired), 32'd1);
            run = 1'b0;
        end

        // Illegal opcode traps in DECODE and ignores run.
        clear_mem();
        rom[0] = 12'hE00;
        reset_dut();
        run = 1'b1;
        repeat (3) tick();
        check("ill_flag",    32'(illegal),  32'd1);
        check("ill_halted",  32'(halted),   32'd1);
        check("ill_pc",      32'(rom_addr), 32'd0);
        check("ill_retired", 32'(retired),  32'd0);
        repeat (8) tick();
        check("ill_stuck_halted", 32'(halted), 32'd1);
        check("ill_stuck_busy",   32'(busy),   32'd0);
        reset_dut();
        check("ill_cleared", 32'(illegal), 32'd0);

        // halt_req raised in EXEC: instruction completes, then HALT, then resume.
        clear_mem();
        rom[0] = 12'h042;
        rf[1] = 5'd1;
        rf[0] = 5'd1;
        reset_dut();
        run = 1'b1;
        repeat (3) tick();
        halt_req = 1'b1;
        tick();
        check("hlt_wb_wr_en", 32'(rf_wr_en), 32'd1);
        tick();
        check("hlt_halted",  32'(halted),   32'd1);
        check("hlt_busy",    32'(busy),     32'd0);
        check("hlt_pc",      32'(rom_addr), 32'd1);
        check("hlt_retired", 32'(retired),  32'd1);
        halt_req = 1'b0;
        tick();
        check("hlt_resume_busy", 32'(busy),   32'd1);
        check("hlt_resume_hltd", 32'(halted), 32'd0);
        repeat (4) tick();
        check("hlt_resume_pc",  32'(rom_addr), 32'd2);
        check("hlt_resume_ret", 32'(retired),  32'd2);

        // run dropped mid-instruction: finishes, then IDLE.
        clear_mem();
        rom[0] = 12'h042;
        reset_dut();
        run = 1'b1;
        repeat (3) tick();
        run = 1'b0;
        tick();
        check("rdrop_wr_en", 32'(rf_wr_en), 32'd1);
        tick();
        check("rdrop_busy", 32'(busy),     32'd0);
        check("rdrop_pc",   32'(rom_addr), 32'd1);
        repeat (3) tick();
        check("rdrop_idle_pc", 32'(rom_addr), 32'd1);
        check("rdrop_idle_hl", 32'(halted),   32'd0);

        // Reset during EXEC aborts the pending write.
        clear_mem();
        rom[0] = 12'h042;
        rf[1] = 5'd1;
        rf[0] = 5'd1;
        reset_dut();
        run = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("rexec_wr_en",   32'(rf_wr_en), 32'd0);
        check("rexec_busy",    32'(busy),     32'd0);
        check("rexec_pc",      32'(rom_addr), 32'd0);
        check("rexec_retired", 32'(retired),  32'd0);
        rst = 1'b0;
        run = 1'b0;
        tick();
        check("rexec_no_late_wr", 32'(rf_wr_en), 32'd0);
        check("rexec_r2_intact",  32'(rf[2]),    32'd0);

        // IDLE with run and halt_req together goes to HALT.
        reset_dut();
        run = 1'b1;
        halt_req = 1'b1;
        tick();
        check("idle_halt_wins", 32'(halted), 32'd1);
        check("idle_halt_busy", 32'(busy),   32'd0);
        halt_req = 1'b0;
        tick();
        check("idle_halt_exit", 32'(busy), 32'd1);

        // Jump to 7, then run ALU ops across the wrap and into counter saturation.
        clear_mem();
        rom[0] = 12'h208;
        rf[1] = 5'd7;
        reset_dut();
        run = 1'b1;
        tick();
        halt_req = 1'b1;
        repeat (4) tick();
        check("wrap_start_pc", 32'(rom_addr), 32'd7);
        check("wrap_start_hl", 32'(halted),   32'd1);
        for (int k = 0; k < 8; k++) rom[k] = 12'h000;
        halt_req = 1'b0;
        repeat (5) tick();
        check("wrap_pc0", 32'(rom_addr), 32'd0);
        repeat (28) tick();
        check("wrap_pc7",     32'(rom_addr), 32'd7);
        check("wrap_retired", 32'(retired),  32'd9);
        repeat (292 * 4) tick();
        check("retired_sat", 32'(retired), 32'd255);
        check("sat_busy",    32'(busy),    32'd1);

`ifdef SEQ_STEP_EN
        // One instruction per step pulse.
        clear_mem();
        reset_dut();
        run = 1'b1;
        repeat (5) tick();
        check("step_pause_busy", 32'(busy),     32'd0);
        check("step_pause_pc",   32'(rom_addr), 32'd1);
        repeat (3) tick();
        check("step_hold_pc",    32'(rom_addr), 32'd1);
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (4) tick();
        check("step_one_pc",  32'(rom_addr), 32'd2);
        check("step_one_ret", 32'(retired),  32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
